// File: rtl/boot_load_ctrl_pkg.sv
// Shared encodings and constants for the instruction-RAM boot/load sequencer.
package boot_load_ctrl_pkg;

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   typedef enum logic [1:0] {
      StHold  = ST_HOLD,
      StRun   = ST_RUN,
      StLoad  = ST_LOAD,
      StFlush = ST_FLUSH
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/boot_load_ctrl_if.sv
// Host byte stream plus the single instruction-RAM port; master is the sequencer side.
interface boot_load_ctrl_if #(
   parameter int unsigned DEPTH_I = 8,
   parameter int unsigned WIDTH_I = 32
);

   logic [7:0]         s_data;
   logic               s_valid;
   logic               s_ready;
   logic [DEPTH_I-1:0] ram_addr;
   logic               ram_we;
   logic [WIDTH_I-1:0] ram_wdata;

   modport master (
      input  s_data,
      input  s_valid,
      output s_ready,
      output ram_addr,
      output ram_we,
      output ram_wdata
   );

   modport slave (
      output s_data,
      output s_valid,
      input  s_ready,
      input  ram_addr,
      input  ram_we,
      input  ram_wdata
   );

endinterface

// File: rtl/boot_load_ctrl_word_assembler.sv
// Little-endian 8-to-32 packer; word_valid pulses the cycle after the 4th byte of a word.
module word_assembler
   import boot_load_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic [BYTE_IDX_W-1:0] byte_idx,
   output logic                  word_valid,
   output logic [31:0]           word_data
);

   logic [BYTE_IDX_W-1:0] idx_q, idx_d;
   logic [23:0]           buf_q, buf_d;
   logic                  valid_q, valid_d;
   logic [31:0]           word_q, word_d;

   always_comb begin
      idx_d   = idx_q;
      buf_d   = buf_q;
      valid_d = 1'b0;
      word_d  = word_q;
      if (clear) begin
         idx_d = '0;
      end else if (byte_valid) begin
         if (idx_q == LAST_BYTE) begin
            word_d  = {byte_data, buf_q};
            valid_d = 1'b1;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + BYTE_IDX_W'(1);
            unique case (idx_q)
               2'd0:    buf_d[7:0]   = byte_data;
               2'd1:    buf_d[15:8]  = byte_data;
               default: buf_d[23:16] = byte_data;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         buf_q   <= '0;
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign byte_idx   = idx_q;
   assign word_valid = valid_q;
   assign word_data  = word_q;

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot/load sequencer: holds sc1_cpu in reset, reloads its instruction RAM from a host
// byte stream on request, and muxes the single RAM address port between CPU and loader.
module boot_load_ctrl
   import boot_load_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_I     = 8,
   parameter int unsigned WIDTH_I     = 32,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   boot_load_ctrl_if.master   bus,
   input  logic               load_req,
   input  logic [DEPTH_I:0]   load_words,
   input  logic [DEPTH_I-1:0] cpu_addr,
   output logic               cpu_reset,
   output logic               busy,
   output logic               done,
   output logic [31:0]        checksum
);

   localparam int unsigned      HCW       = $clog2(HOLD_CYCLES);
   localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_CYCLES - 1);
   localparam logic [DEPTH_I:0] MAX_WORDS = {1'b1, {DEPTH_I{1'b0}}};

   state_e             state_q, state_d;
   logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
   logic               done_q, done_d;
   logic               load_start;

   logic [DEPTH_I:0]   word_idx_q;
   logic [DEPTH_I:0]   word_tgt_q;
   logic [DEPTH_I:0]   tgt_clamped;
   logic [31:0]        checksum_q;
   logic               all_bytes_q;

   logic                  byte_acc;
   logic                  last_byte;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic                  word_valid;
   logic [31:0]           word_data;
   logic [WIDTH_I-1:0]    wdata;
   logic                  ram_we;

   // ---------------------------------------------------------------- state machine
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;
      load_start = 1'b0;
      unique case (state_q)
         StHold: begin
            if (load_req) begin
               hold_cnt_d = '0;
               if (load_words == '0) begin
                  state_d = StRun;
               end else begin
                  state_d    = StLoad;
                  load_start = 1'b1;
               end
            end else if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               state_d    = StRun;
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
         StRun: begin
            if (load_req && (load_words != '0)) begin
               state_d    = StLoad;
               load_start = 1'b1;
            end
         end
         StLoad: begin
            // all_bytes_q is already set during the write of the final word
            if (ram_we && all_bytes_q) begin
               state_d    = StFlush;
               hold_cnt_d = '0;
            end
         end
         default: begin
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               state_d    = StRun;
               done_d     = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StHold;
         hold_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         done_q     <= done_d;
      end
   end

   // ---------------------------------------------------------------- load datapath
   assign tgt_clamped = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
   assign byte_acc    = bus.s_valid & bus.s_ready;
   // The previous word is always written before the 4th byte of this one lands,
   // so word_idx_q already names the word being assembled.
   assign last_byte   = (byte_idx == LAST_BYTE) &&
                        (word_idx_q == (word_tgt_q - (DEPTH_I + 1)'(1)));

   word_assembler u_word_assembler (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (load_start),
      .byte_valid (byte_acc),
      .byte_data  (bus.s_data),
      .byte_idx   (byte_idx),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_idx_q  <= '0;
         word_tgt_q  <= '0;
         checksum_q  <= '0;
         all_bytes_q <= 1'b0;
      end else if (load_start) begin
         word_idx_q  <= '0;
         word_tgt_q  <= tgt_clamped;
         checksum_q  <= '0;
         all_bytes_q <= 1'b0;
      end else begin
         if (ram_we) begin
            word_idx_q <= word_idx_q + (DEPTH_I + 1)'(1);
            checksum_q <= checksum_q + word_data;
         end
         if (byte_acc && last_byte) begin
            all_bytes_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign ram_we        = word_valid & (state_q == StLoad);
   assign wdata         = word_data;
   assign bus.s_ready   = (state_q == StLoad) & ~all_bytes_q;
   assign bus.ram_we    = ram_we;
   assign bus.ram_wdata = wdata;
   assign bus.ram_addr  = (state_q == StRun) ? cpu_addr : word_idx_q[DEPTH_I-1:0];

   assign cpu_reset = (state_q != StRun);
   assign busy      = (state_q != StRun);
   assign done      = done_q;
   assign checksum  = checksum_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl: power-up hold, loads with and without gaps,
// clamped full-depth load, zero-word request and reset in the middle of a load.
module tb_boot_load_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       load_req;
   logic [8:0] load_words;
   logic [7:0] cpu_addr;
   logic       cpu_reset;
   logic       busy;
   logic       done;
   logic [31:0] checksum;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [7:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   always #5 clk = ~clk;

   boot_load_ctrl_if #(.DEPTH_I(8), .WIDTH_I(32)) bif ();

   boot_load_ctrl #(
      .DEPTH_I     (8),
      .WIDTH_I     (32),
      .HOLD_CYCLES (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bif.master),
      .load_req   (load_req),
      .load_words (load_words),
      .cpu_addr   (cpu_addr),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   always @(negedge clk) begin
      if (reset_n && bif.ram_we) begin
         wr_addr.push_back(bif.ram_addr);
         wr_data.push_back(bif.ram_wdata);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output int stalls, output bit ok);
      ok = 1'b0;
      stalls = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         bif.s_valid = 1'b1;
         bif.s_data  = b;
         if (bif.s_ready) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         stalls++;
      end
   endtask

   task automatic send_stream(input logic [7:0] bytes[$], input int gap,
                              output int stalls, output int fails);
      int s;
      bit ok;
      stalls = 0;
      fails  = 0;
      for (int i = 0; i < bytes.size(); i++) begin
         send_byte(bytes[i], s, ok);
         stalls += s;
         if (!ok) fails++;
         if (i != bytes.size() - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               bif.s_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic pulse_load(input logic [8:0] w);
      @(negedge clk);
      load_req   = 1'b1;
      load_words = w;
      @(negedge clk);
      load_req   = 1'b0;
   endtask

   task automatic measure_hold(output int n);
      n = 0;
      while (cpu_reset && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Called right after the accepting edge of the final byte.
   task automatic finish_load(input string tag, input logic [31:0] exp_sum);
      int k;
      int rst_low;
      int d0;
      d0 = done_cnt;
      rst_low = 0;
      @(negedge clk);
      bif.s_valid = 1'b0;
      k = 1;
      check({tag, "_ready_low"}, bif.s_ready, 1'b0);
      check({tag, "_final_we"}, bif.ram_we, 1'b1);
      while (!done && k < 100) begin
         if (!cpu_reset) rst_low++;
         @(negedge clk);
         k++;
      end
      check({tag, "_done_latency"}, k, 18);
      check({tag, "_reset_held"}, rst_low, 0);
      check({tag, "_run_reset"}, cpu_reset, 1'b0);
      check({tag, "_checksum"}, checksum, exp_sum);
      @(negedge clk);
      check({tag, "_done_once"}, done_cnt - d0, 1);
      check({tag, "_done_low"}, done, 1'b0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  q[$];
      logic [31:0] exp_sum;
      logic [31:0] w;
      int n, stalls, fails, bad, d0;

      reset_n     = 1'b0;
      load_req    = 1'b0;
      load_words  = '0;
      cpu_addr    = 8'h5A;
      bif.s_valid = 1'b0;
      bif.s_data  = '0;

      // ---- reset values and power-up hold
      #1;
      check("rst_cpu_reset", cpu_reset, 1'b1);
      check("rst_s_ready", bif.s_ready, 1'b0);
      check("rst_ram_we", bif.ram_we, 1'b0);
      check("rst_ram_wdata", bif.ram_wdata, 32'h0);
      check("rst_done", done, 1'b0);
      check("rst_checksum", checksum, 32'h0);
      check("rst_busy", busy, 1'b1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      measure_hold(n);
      check("pwr_hold_cycles", n, 16);
      check("pwr_busy", busy, 1'b0);
      check("pwr_ram_addr", bif.ram_addr, 8'h5A);
      cpu_addr = 8'h33;
      #1;
      check("run_addr_comb", bif.ram_addr, 8'h33);
      check("pwr_no_done", done_cnt, 0);

      // ---- two-word load, back-to-back bytes
      wr_addr.delete();
      wr_data.delete();
      pulse_load(9'd2);
      check("ld_cpu_reset", cpu_reset, 1'b1);
      check("ld_s_ready", bif.s_ready, 1'b1);
      q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_stream(q, 0, stalls, fails);
      check("b2b_sent", fails, 0);
      check("b2b_stalls", stalls, 0);
      finish_load("b2b", 32'hCCAA8866);
      check("b2b_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("b2b_a0", wr_addr[0], 8'd0);
         check("b2b_d0", wr_data[0], 32'h44332211);
         check("b2b_a1", wr_addr[1], 8'd1);
         check("b2b_d1", wr_data[1], 32'h88776655);
      end

      // ---- same load with 3-cycle gaps between bytes
      wr_addr.delete();
      wr_data.delete();
      pulse_load(9'd2);
      send_stream(q, 3, stalls, fails);
      check("gap_sent", fails, 0);
      check("gap_stalls", stalls, 0);
      finish_load("gap", 32'hCCAA8866);
      check("gap_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("gap_d0", wr_data[0], 32'h44332211);
         check("gap_a1", wr_addr[1], 8'd1);
         check("gap_d1", wr_data[1], 32'h88776655);
      end

      // ---- oversize request clamps to 256 words
      wr_addr.delete();
      wr_data.delete();
      q.delete();
      for (int i = 0; i < 1024; i++) q.push_back(8'((i * 7 + 3) & 255));
      exp_sum = '0;
      for (int i = 0; i < 256; i++) begin
         w = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
         exp_sum += w;
      end
      pulse_load(9'd300);
      send_stream(q, 0, stalls, fails);
      check("big_sent", fails, 0);
      finish_load("big", exp_sum);
      check("big_nwr", wr_addr.size(), 256);
      bad = 0;
      for (int i = 0; i < wr_addr.size() && i < 256; i++) begin
         w = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
         if (wr_addr[i] != 8'(i) || wr_data[i] != w) bad++;
      end
      check("big_writes_bad", bad, 0);

      // ---- zero-word request in RUN is ignored
      pulse_load(9'd0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (cpu_reset || busy || bif.s_ready) n++;
         @(negedge clk);
      end
      check("zero_ignored", n, 0);

      // ---- reset in the middle of a four-word load
      wr_addr.delete();
      wr_data.delete();
      d0 = done_cnt;
      pulse_load(9'd4);
      q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      send_stream(q, 0, stalls, fails);
      check("mid_sent", fails, 0);
      #2;
      check("mid_sum_before", checksum, 32'hD4C3B2A1);
      check("mid_nwr", wr_addr.size(), 1);
      reset_n = 1'b0;
      #1;
      check("mid_ram_we", bif.ram_we, 1'b0);
      check("mid_cpu_reset", cpu_reset, 1'b1);
      check("mid_checksum", checksum, 32'h0);
      check("mid_s_ready", bif.s_ready, 1'b0);
      bif.s_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      measure_hold(n);
      check("mid_hold_cycles", n, 16);
      check("mid_run", busy, 1'b0);
      repeat (4) @(negedge clk);
      check("mid_no_done", done_cnt - d0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
